// File: rtl/taiga_types.sv
// Shared L1 types: burst-size encoding common to the arbiter request and the responder.
package taiga_types;

  localparam int unsigned BurstSizeW = 5;

  typedef logic [BurstSizeW-1:0] burst_size_t;

  // Legal size encodings: burst length minus one
  localparam burst_size_t BurstLen1  = 5'd0;
  localparam burst_size_t BurstLen2  = 5'd1;
  localparam burst_size_t BurstLen4  = 5'd3;
  localparam burst_size_t BurstLen8  = 5'd7;
  localparam burst_size_t BurstLen16 = 5'd15;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StBurst
  } resp_state_e;

  // Drop bit 4, then round down to the nearest legal encoding
  function automatic burst_size_t legalize_size(input burst_size_t raw);
    burst_size_t s;
    s = raw & 5'b01111;
    if (s == BurstLen16)     return BurstLen16;
    else if (s >= BurstLen8) return BurstLen8;
    else if (s >= BurstLen4) return BurstLen4;
    else if (s >= BurstLen2) return BurstLen2;
    else                     return BurstLen1;
  endfunction

endpackage

// File: rtl/byte_en_BRAM.sv
// Simple dual-port block RAM: port a registered read, port b byte-enabled write.
// Contents are never reset so they survive a responder reset.
module byte_en_BRAM #(
  parameter int unsigned Depth = 4096
) (
  input  logic                     clk,
  input  logic                     en_a_i,
  input  logic [$clog2(Depth)-1:0] addr_a_i,
  output logic [31:0]              data_a_o,
  input  logic                     en_b_i,
  input  logic [$clog2(Depth)-1:0] addr_b_i,
  input  logic [3:0]               be_b_i,
  input  logic [31:0]              data_b_i
);

  logic [31:0] mem_q [Depth];
  logic [31:0] data_a_q;

  // Port a: one-cycle registered read
  always_ff @(posedge clk) begin
    if (en_a_i) begin
      data_a_q <= mem_q[addr_a_i];
    end
  end

  // Port b: write only the enabled byte lanes
  always_ff @(posedge clk) begin
    if (en_b_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_b_i[b]) begin
          mem_q[addr_b_i][8*b +: 8] <= data_b_i[8*b +: 8];
        end
      end
    end
  end

  assign data_a_o = data_a_q;

endmodule

// File: rtl/l1_mem_responder.sv
// L1 memory responder: single-word byte-enabled writes complete at ack,
// aligned read bursts return after a fixed latency with no gaps.
module l1_mem_responder
  import taiga_types::*;
#(
  parameter int unsigned MEM_WORDS    = 4096,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request,
  input  logic [31:0] addr,
  input  logic        rnw,
  input  logic [4:0]  size,
  input  logic [3:0]  be,
  input  logic [31:0] data,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        data_valid,
  output logic        busy
);

  localparam int unsigned IdxW = $clog2(MEM_WORDS);
  // Last WAIT count; the fetch for beat 0 is issued in that cycle
  localparam logic [2:0] LastWait = 3'(READ_LATENCY - 2);

  resp_state_e     state_q, state_d;
  logic [2:0]      lat_q, lat_d;
  logic [3:0]      beat_q, beat_d;
  burst_size_t     size_q, size_d;
  logic [IdxW-1:0] rd_idx_q, rd_idx_d;

  burst_size_t     size_legal;
  logic            rd_en;
  logic            wr_en;
  logic [31:0]     bram_rdata;
  logic            unused_addr;

  assign unused_addr = ^addr[1:0];
  assign size_legal  = legalize_size(size);

  assign ack        = request && (state_q == StIdle) && !rst;
  assign wr_en      = ack && !rnw;
  assign data_valid = (state_q == StBurst);
  assign busy       = (state_q != StIdle);
  assign rdata      = data_valid ? bram_rdata : 32'h0;

  // Next-state: accept reads, count latency, then stream beats with one-ahead prefetch
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    beat_d   = beat_q;
    size_d   = size_q;
    rd_idx_d = rd_idx_q;
    rd_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ack && rnw) begin
          size_d   = size_legal;
          rd_idx_d = IdxW'(addr[31:2] & ~{25'b0, size_legal});
          lat_d    = 3'd0;
          beat_d   = 4'd0;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (lat_q == LastWait) begin
          rd_en    = 1'b1;
          rd_idx_d = rd_idx_q + 1'b1;
          state_d  = StBurst;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      StBurst: begin
        if ({1'b0, beat_q} == size_q) begin
          state_d = StIdle;
        end else begin
          rd_en    = 1'b1;
          rd_idx_d = rd_idx_q + 1'b1;
          beat_d   = beat_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and counters, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      lat_q    <= 3'd0;
      beat_q   <= 4'd0;
      size_q   <= BurstLen1;
      rd_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      beat_q   <= beat_d;
      size_q   <= size_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  byte_en_BRAM #(
    .Depth(MEM_WORDS)
  ) u_bram (
    .clk     (clk),
    .en_a_i  (rd_en),
    .addr_a_i(rd_idx_q),
    .data_a_o(bram_rdata),
    .en_b_i  (wr_en),
    .addr_b_i(IdxW'(addr[31:2])),
    .be_b_i  (be),
    .data_b_i(data)
  );

endmodule

// File: tb/tb_l1_mem_responder.sv
// Randomized self-checking bench for l1_mem_responder against a word-array memory model.
module tb_l1_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        sel;
  logic [31:0] addr;
  logic        rnw;
  logic [4:0]  size;
  logic [3:0]  be;
  logic [31:0] data;

  logic        ack0, dv0, busy0, ack5, dv5, busy5;
  logic [31:0] rdata0, rdata5;
  logic        ack_m, dv_m, busy_m;
  logic [31:0] rdata_m;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem0 [4096];
  logic [31:0] mem5 [64];

  always #5 clk = ~clk;

  l1_mem_responder u_dut (
    .clk       (clk),
    .rst       (rst),
    .request   (req && !sel),
    .addr      (addr),
    .rnw       (rnw),
    .size      (size),
    .be        (be),
    .data      (data),
    .ack       (ack0),
    .rdata     (rdata0),
    .data_valid(dv0),
    .busy      (busy0)
  );

  l1_mem_responder #(
    .MEM_WORDS   (64),
    .READ_LATENCY(5)
  ) u_dut_lat5 (
    .clk       (clk),
    .rst       (rst),
    .request   (req && sel),
    .addr      (addr),
    .rnw       (rnw),
    .size      (size),
    .be        (be),
    .data      (data),
    .ack       (ack5),
    .rdata     (rdata5),
    .data_valid(dv5),
    .busy      (busy5)
  );

  assign ack_m   = sel ? ack5   : ack0;
  assign dv_m    = sel ? dv5    : dv0;
  assign busy_m  = sel ? busy5  : busy0;
  assign rdata_m = sel ? rdata5 : rdata0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_rd(input int idx);
    if (sel) return mem5[idx % 64];
    else     return mem0[idx % 4096];
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    int idx;
    req = 1'b1; rnw = 1'b0; addr = a; data = d; be = b;
    @(negedge clk);
    check_eq("wr_ack", ack_m, 1);
    @(posedge clk); #1;
    req = 1'b0;
    idx = int'((a >> 2) % (sel ? 64 : 4096));
    for (int j = 0; j < 4; j++) begin
      if (b[j]) begin
        if (sel) mem5[idx][8*j +: 8] = d[8*j +: 8];
        else     mem0[idx][8*j +: 8] = d[8*j +: 8];
      end
    end
    check_eq("wr_busy", busy_m, 0);
  endtask

  // abort_beat >= 0 pulses rst during that beat; poke raises a write request during WAIT
  task automatic do_read(input logic [31:0] a, input logic [4:0] sz, input int abort_beat,
                         input bit poke);
    int mw, lat, s, n, start;
    mw  = sel ? 64 : 4096;
    lat = sel ? 5 : 2;
    s = int'(sz) % 16;
    n = 1;
    while (2 * n - 1 <= s) n = 2 * n;
    start = int'(((a >> 2) % mw) / n * n);
    req = 1'b1; rnw = 1'b1; addr = a; size = sz;
    @(negedge clk);
    check_eq("rd_ack", ack_m, 1);
    @(posedge clk); #1;
    req = 1'b0; addr = $urandom; size = 5'($urandom);
    for (int c = 1; c < lat; c++) begin
      if (poke && c == 1) begin
        req = 1'b1; rnw = 1'b0; addr = 32'h24; data = 32'h0; be = 4'hF;
      end
      @(negedge clk);
      check_eq("wait_dv", dv_m, 0);
      check_eq("wait_busy", busy_m, 1);
      check_eq("wait_rdata", rdata_m, 0);
      if (poke && c == 1) check_eq("busy_no_ack", ack_m, 0);
      @(posedge clk); #1;
      req = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      if (k == abort_beat) rst = 1'b1;
      @(negedge clk);
      check_eq("beat_dv", dv_m, 1);
      check_eq("beat_data", rdata_m, model_rd(start + k));
      @(posedge clk); #1;
      if (k == abort_beat) begin
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort_dv", dv_m, 0);
        check_eq("abort_busy", busy_m, 0);
        check_eq("abort_rdata", rdata_m, 0);
        @(posedge clk); #1;
        return;
      end
    end
    check_eq("end_busy", busy_m, 0);
    check_eq("end_dv", dv_m, 0);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; sel = 1'b0; addr = '0; rnw = 1'b1;
    size = '0; be = '0; data = '0;
    repeat (3) @(posedge clk);
    #1;
    req = 1'b1;
    @(negedge clk);
    check_eq("rst_ack", ack0, 0);
    check_eq("rst_dv", dv0, 0);
    check_eq("rst_busy", busy0, 0);
    check_eq("rst_rdata", rdata0, 0);
    @(posedge clk); #1;
    req = 1'b0; rst = 1'b0;

    for (int i = 0; i < 4096; i++) do_write(32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF);

    // Aligned burst from mid-block address
    do_read(32'h48, 5'd7, -1, 1'b0);
    // Partial byte write then immediate read-back
    do_write(32'h10, 32'hFFFF_FFFF, 4'hF);
    do_write(32'h10, 32'h1122_3344, 4'b0101);
    do_read(32'h10, 5'd0, -1, 1'b0);
    check_eq("merge_model", mem0[4], 32'hFF22_FF44);
    // Zero byte enables leave memory unchanged
    do_write(32'h14, 32'hDEAD_BEEF, 4'h0);
    do_read(32'h14, 5'd0, -1, 1'b0);
    // Request while busy is ignored
    do_read(32'h40, 5'd3, -1, 1'b1);
    do_read(32'h24, 5'd0, -1, 1'b0);
    // Reset mid-burst, then immediate re-read
    do_read(32'h100, 5'd15, 2, 1'b0);
    do_read(32'h100, 5'd15, -1, 1'b0);
    // Top-of-memory block, back-to-back
    do_read(32'((4096 - 4) * 4), 5'd3, -1, 1'b0);
    do_read(32'h0000_4004, 5'd1, -1, 1'b0);
    // Illegal sizes round down
    do_read(32'h200, 5'd21, -1, 1'b0);
    do_read(32'h300, 5'd14, -1, 1'b0);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 2) == 0) do_write($urandom, $urandom, 4'($urandom));
      else                           do_read($urandom, 5'($urandom), -1, 1'b0);
    end

    // Longer-latency, smaller build
    sel = 1'b1;
    for (int i = 0; i < 64; i++) do_write(32'(i * 4), 32'hB000_0000 + 32'(i), 4'hF);
    do_read(32'h8, 5'd1, -1, 1'b0);
    do_read(32'h4C, 5'd15, -1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) do_write($urandom, $urandom, 4'($urandom));
      else                           do_read($urandom, 5'($urandom), -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
